// File: rtl/pc_sequencer_pkg.sv
// Shared constants and state encoding for the program-counter sequencer.
package pc_sequencer_pkg;
    localparam int DEF_AW = 10;
    localparam int DEF_NWORDS = 16;
    localparam logic [DEF_AW-1:0] DEF_RESET_PC = 10'h000;
    localparam logic [DEF_AW-1:0] DEF_IRQ_VEC = 10'h001;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
endpackage

// File: rtl/pc_sequencer_stack_depth_tracker.sv
// Shadow occupancy counter for the external return stack; qualifies push/pop
// requests and flags the ones that would overflow or underflow.
module pc_sequencer_stack_depth_tracker #(
    parameter int NWORDS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    output logic                     push_ok,
    output logic                     pop_ok,
    output logic                     overflow,
    output logic                     underflow,
    output logic [$clog2(NWORDS):0]  depth
);
    localparam int DW = $clog2(NWORDS) + 1;
    localparam logic [DW-1:0] FULL = DW'(NWORDS);

    logic full;
    logic empty;

    always_comb begin
        full      = (depth == FULL);
        empty     = (depth == '0);
        push_ok   = push_req && !full;
        overflow  = push_req && full;
        pop_ok    = pop_req && !empty;
        underflow = pop_req && empty;
    end

    // The top never requests push and pop together, so one increment or
    // decrement per cycle is enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
        end else if (push_ok) begin
            depth <= depth + 1'b1;
        end else if (pop_ok) begin
            depth <= depth - 1'b1;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, call/return strobes toward stack_module, interrupt entry
// as a forced call, and RUN/HALT/FAULT control for the 10-bit processor.
import pc_sequencer_pkg::*;

module pc_sequencer #(
    parameter int              AW       = DEF_AW,
    parameter int              NWORDS   = DEF_NWORDS,
    parameter logic [AW-1:0]   RESET_PC = DEF_RESET_PC,
    parameter logic [AW-1:0]   IRQ_VEC  = DEF_IRQ_VEC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run_en,
    input  logic                     jump,
    input  logic                     jal,
    input  logic                     ret,
    input  logic                     reti,
    input  logic                     halt,
    input  logic                     irq,
    input  logic [AW-1:0]            target,
    input  logic [AW-1:0]            stk_top,
    output logic [AW-1:0]            pc,
    output logic                     we_stack,
    output logic                     s_jalret,
    output logic [AW-1:0]            stk_wdata,
    output logic [$clog2(NWORDS):0]  depth,
    output logic                     irq_ack,
    output logic                     fault,
    output logic                     halted,
    output logic [1:0]               state_dbg
);
    state_t        state_q, state_d;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_inc;
    logic          irq_mask, irq_mask_d;
    logic          fault_d;
    logic          irq_ack_d;
    logic          active;
    logic          take_irq;
    logic          do_ret;
    logic          push_req, pop_req;
    logic          push_ok, pop_ok;
    logic          overflow, underflow;

    pc_sequencer_stack_depth_tracker #(.NWORDS(NWORDS)) u_depth (
        .clk       (clk),
        .rst_n     (reset),
        .push_req  (push_req),
        .pop_req   (pop_req),
        .push_ok   (push_ok),
        .pop_ok    (pop_ok),
        .overflow  (overflow),
        .underflow (underflow),
        .depth     (depth)
    );

    // Strobe decode: interrupt entry outranks return, return outranks call.
    always_comb begin
        pc_inc    = pc + 1'b1;
        active    = run_en && (state_q == ST_RUN);
        take_irq  = irq && !irq_mask;
        do_ret    = ret || reti;
        push_req  = active && (take_irq || (!do_ret && jal));
        pop_req   = active && !take_irq && do_ret;
        stk_wdata = take_irq ? pc : pc_inc;
        we_stack  = push_ok || pop_ok;
        s_jalret  = pop_ok;
        halted    = (state_q != ST_RUN);
        state_dbg = state_q;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc;
        irq_mask_d = irq_mask;
        fault_d    = fault;
        irq_ack_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (run_en) begin
                    if (overflow || underflow) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else if (take_irq) begin
                        pc_d       = IRQ_VEC;
                        irq_mask_d = 1'b1;
                        irq_ack_d  = 1'b1;
                    end else if (do_ret) begin
                        pc_d = stk_top;
                        if (reti) irq_mask_d = 1'b0;
                    end else if (jal || jump) begin
                        pc_d = target;
                    end else if (halt) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HALT: begin
                // Wake only; the interrupt itself is taken on the next RUN cycle.
                if (run_en && take_irq) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            pc       <= RESET_PC;
            irq_mask <= 1'b0;
            fault    <= 1'b0;
            irq_ack  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc       <= pc_d;
            irq_mask <= irq_mask_d;
            fault    <= fault_d;
            irq_ack  <= irq_ack_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based model
// of the return stack and the documented next-PC priority rules.
module tb_pc_sequencer;
    localparam int NW = 16;

    localparam int OP_HOLD = 0;
    localparam int OP_ADV  = 1;
    localparam int OP_IRQ  = 2;
    localparam int OP_POP  = 3;
    localparam int OP_CALL = 4;
    localparam int OP_JMP  = 5;
    localparam int OP_HLT  = 6;
    localparam int OP_FLT  = 7;
    localparam int OP_WAKE = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       run_en, jump, jal, ret, reti, halt, irq;
    logic [9:0] target, stk_top;
    logic [9:0] pc, stk_wdata;
    logic       we_stack, s_jalret, irq_ack, fault, halted;
    logic [4:0] depth;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_fail = 0;

    // Model: stk_q is the return stack, m_state 0=run 1=halt 2=fault.
    logic [9:0] stk_q[$];
    logic [9:0] m_pc;
    logic       m_mask;
    logic       m_fault;
    logic       m_ack;
    int         m_state;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .jump      (jump),
        .jal       (jal),
        .ret       (ret),
        .reti      (reti),
        .halt      (halt),
        .irq       (irq),
        .target    (target),
        .stk_top   (stk_top),
        .pc        (pc),
        .we_stack  (we_stack),
        .s_jalret  (s_jalret),
        .stk_wdata (stk_wdata),
        .depth     (depth),
        .irq_ack   (irq_ack),
        .fault     (fault),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic model_reset();
        stk_q.delete();
        m_pc    = 10'h000;
        m_mask  = 1'b0;
        m_fault = 1'b0;
        m_ack   = 1'b0;
        m_state = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
        chk({tag, "_depth"}, 32'(depth), 32'(stk_q.size()));
        chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
        chk({tag, "_halted"}, 32'(halted), 32'(m_state != 0));
        chk({tag, "_irq_ack"}, 32'(irq_ack), 32'(m_ack));
    endtask

    // Called at posedge+1; reset is asserted between edges.
    task automatic do_reset(input string tag);
        {run_en, jump, jal, ret, reti, halt, irq} = 7'b0;
        reset = 1'b0;
        #2;
        model_reset();
        chk_regs(tag);
        chk({tag, "_we"}, 32'(we_stack), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One clock of stimulus: combinational strobes checked mid-cycle,
    // registered state checked just after the edge.
    task automatic step(input string tag, input logic re, input logic j, input logic jl,
                        input logic r, input logic ri, input logic h, input logic iq,
                        input logic [9:0] tg);
        int         op;
        logic       full;
        logic [9:0] nxt;
        run_en = re; jump = j; jal = jl; ret = r; reti = ri; halt = h; irq = iq;
        target = tg;
        stk_top = (stk_q.size() > 0) ? stk_q[$] : 10'h000;
        full = (stk_q.size() == NW);
        nxt = m_pc + 10'd1;
        if (m_state == 0 && re) begin
            if (iq && !m_mask)   op = full ? OP_FLT : OP_IRQ;
            else if (r || ri)    op = (stk_q.size() == 0) ? OP_FLT : OP_POP;
            else if (jl)         op = full ? OP_FLT : OP_CALL;
            else if (j)          op = OP_JMP;
            else if (h)          op = OP_HLT;
            else                 op = OP_ADV;
        end else if (m_state == 1 && re && iq && !m_mask) begin
            op = OP_WAKE;
        end else begin
            op = OP_HOLD;
        end
        #2;
        chk({tag, "_we"}, 32'(we_stack), 32'(op == OP_IRQ || op == OP_POP || op == OP_CALL));
        if (op == OP_IRQ || op == OP_POP || op == OP_CALL)
            chk({tag, "_dir"}, 32'(s_jalret), 32'(op == OP_POP));
        if (op == OP_IRQ || op == OP_CALL)
            chk({tag, "_wdata"}, 32'(stk_wdata), 32'((op == OP_IRQ) ? m_pc : nxt));
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        case (op)
            OP_ADV:  m_pc = nxt;
            OP_IRQ:  begin stk_q.push_back(m_pc); m_pc = 10'h001; m_mask = 1'b1; m_ack = 1'b1; end
            OP_POP:  begin m_pc = stk_q.pop_back(); if (ri && !r) m_mask = 1'b0; if (ri) m_mask = 1'b0; end
            OP_CALL: begin stk_q.push_back(nxt); m_pc = tg; end
            OP_JMP:  m_pc = tg;
            OP_HLT:  m_state = 1;
            OP_FLT:  begin m_state = 2; m_fault = 1'b1; end
            OP_WAKE: m_state = 0;
            default: ;
        endcase
        chk_regs(tag);
    endtask

    initial begin
        {run_en, jump, jal, ret, reti, halt, irq} = 7'b0;
        target = '0;
        stk_top = '0;
        reset = 1'b0;
        model_reset();
        #3;
        chk_regs("por");
        chk("por_we", 32'(we_stack), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // T1: free-running increment
        for (int i = 0; i < 5; i++) step("t1", 1, 0, 0, 0, 0, 0, 0, 10'h0);

        // T2: call and return
        step("t2_jmp", 1, 1, 0, 0, 0, 0, 0, 10'h010);
        step("t2_jal", 1, 0, 1, 0, 0, 0, 0, 10'h100);
        step("t2_ret", 1, 0, 0, 1, 0, 0, 0, 10'h0);
        do_reset("t2_rst");

        // T3: overflow on the 17th nested call
        for (int i = 0; i < 17; i++) step("t3_jal", 1, 0, 1, 0, 0, 0, 0, 10'(10'h200 + i));
        step("t3_held", 1, 0, 0, 0, 0, 0, 0, 10'h0);
        do_reset("t3_rst");

        // T4: underflow, FAULT ignores further traffic
        step("t4_ret", 1, 0, 0, 1, 0, 0, 0, 10'h0);
        step("t4_irq", 1, 0, 1, 0, 0, 0, 1, 10'h055);
        do_reset("t4_rst");

        // T5: interrupt beats call, masked until reti
        step("t5_jmp", 1, 1, 0, 0, 0, 0, 0, 10'h020);
        step("t5_irq", 1, 0, 1, 0, 0, 0, 1, 10'h3AA);
        step("t5_mask", 1, 0, 0, 0, 0, 0, 1, 10'h0);
        step("t5_reti", 1, 0, 0, 0, 1, 0, 1, 10'h0);
        step("t5_after", 1, 0, 0, 0, 0, 0, 0, 10'h0);
        step("t5_halt", 1, 0, 0, 0, 0, 1, 0, 10'h0);
        step("t5_wake", 1, 0, 0, 0, 0, 0, 1, 10'h0);
        step("t5_take", 1, 0, 0, 0, 0, 0, 1, 10'h0);
        do_reset("t5_rst");

        // T6: wrap, stall, asynchronous reset mid-call
        step("t6_jmp", 1, 1, 0, 0, 0, 0, 0, 10'h3FF);
        step("t6_wrap", 1, 0, 0, 0, 0, 0, 0, 10'h0);
        for (int i = 0; i < 3; i++) step("t6_stall", 0, 1, 1, 0, 0, 0, 1, 10'h123);
        step("t6_jal", 1, 0, 1, 0, 0, 0, 0, 10'h080);
        jal = 1'b1;
        target = 10'h0C0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_async_pc", 32'(pc), 32'h000);
        chk("t6_async_depth", 32'(depth), 32'd0);
        jal = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic re, j, jl, r, ri, h, iq;
            if (m_state == 2 || (m_state == 1 && $urandom_range(0, 7) == 0)) begin
                do_reset("rnd_rst");
            end else begin
                re = ($urandom_range(0, 7) != 0);
                j  = ($urandom_range(0, 9) == 0);
                jl = ($urandom_range(0, 4) == 0);
                r  = (stk_q.size() > 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 40) == 0);
                ri = ($urandom_range(0, 12) == 0) && (stk_q.size() > 0);
                h  = ($urandom_range(0, 30) == 0);
                iq = ($urandom_range(0, 10) == 0);
                step("rnd", re, j, jl, r, ri, h, iq, 10'($urandom_range(0, 1023)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
